// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed serializer with optional parity, 1/2 stop bits
// and a bit period latched from cfg_div at the start of each frame.
//   state    | meaning
//   S_IDLE   | line high, pops as soon as the FIFO holds a word
//   S_START  | start bit (0)
//   S_DATA   | payload bits, LSB first
//   S_PARITY | parity bit (only reachable when PARITY != 0)
//   S_STOP   | stop bit(s); last one pops the next word without an idle gap
module uart_tx_fifo #(
  parameter int PAYLOAD_BITS = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int DIV_W        = 16
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [DIV_W-1:0]             cfg_div,
  input  logic                         tx_valid,
  input  logic [PAYLOAD_BITS-1:0]      tx_data,
  output logic                         tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         tx_busy,
  output logic                         uart_txd
);

  localparam int        AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0] LAST_DATA = 4'(PAYLOAD_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                  state, state_nxt;
  logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [PAYLOAD_BITS-1:0] rd_word;
  logic                    push, pop, fifo_empty;
  logic [PAYLOAD_BITS-1:0] shift_q;
  logic                    par_q, par_nxt;
  logic [DIV_W-1:0]        div_q, div_eff, bit_cnt;
  logic [3:0]              bit_idx;
  logic                    bit_done, txd_nxt;

  assign fifo_empty = (fifo_level == '0);
  assign tx_ready   = (fifo_level != FULL_LVL);
  assign tx_busy    = (state != S_IDLE) || !fifo_empty;
  assign push       = tx_valid && tx_ready;
  assign rd_word    = mem[rd_ptr];
  assign div_eff    = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
  assign bit_done   = (bit_cnt == '0);
  assign par_nxt    = (PARITY == 1) ? ~(^rd_word) : (^rd_word);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + (AW+1)'(1);
        2'b01:   fifo_level <= fifo_level - (AW+1)'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (!fifo_empty) state_nxt = S_START;
      S_START:  if (bit_done) state_nxt = S_DATA;
      S_DATA:   if (bit_done && bit_idx == LAST_DATA)
                  state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (bit_done) state_nxt = S_STOP;
      S_STOP:   if (bit_done && bit_idx == LAST_STOP)
                  state_nxt = fifo_empty ? S_IDLE : S_START;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pop     = 1'b0;
    txd_nxt = 1'b1;
    case (state)
      S_IDLE:   pop     = !fifo_empty;
      S_START:  txd_nxt = 1'b0;
      S_DATA:   txd_nxt = shift_q[0];
      S_PARITY: txd_nxt = par_q;
      S_STOP:   pop     = bit_done && (bit_idx == LAST_STOP) && !fifo_empty;
      default:  txd_nxt = 1'b1;
    endcase
  end

  // Bit timer restarts at every boundary; bit_idx counts bits within DATA or STOP.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      shift_q <= '0;
      par_q   <= 1'b0;
      div_q   <= DIV_W'(1);
      bit_cnt <= '0;
      bit_idx <= '0;
    end else if (pop) begin
      shift_q <= rd_word;
      par_q   <= par_nxt;
      div_q   <= div_eff;
      bit_cnt <= div_eff - DIV_W'(1);
      bit_idx <= '0;
    end else if (state != S_IDLE) begin
      if (bit_done) begin
        bit_cnt <= div_q - DIV_W'(1);
        bit_idx <= (state_nxt == state) ? bit_idx + 4'd1 : 4'd0;
        if (state == S_DATA) shift_q <= shift_q >> 1;
      end else begin
        bit_cnt <= bit_cnt - DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) uart_txd <= 1'b1;
    else         uart_txd <= txd_nxt;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench: stimulus queues expected frames, per-DUT monitors decode the line.
// dut0 = defaults, dut1 = even parity + 2 stop bits, dut2 = odd parity + 1 stop bit.
module tb_uart_tx_fifo;

  typedef struct {
    logic [15:0] bits;
    int          len;
    int          div;
    int          gap;
  } frame_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [15:0] div_r [3];
  logic [2:0] vld;
  logic [7:0] dat [3];
  wire  [2:0] rdy, busy, txd;
  wire  [3:0] lvl [3];

  frame_t exp_q [3][$];
  int     n_assert = 0;
  int     n_fail = 0;
  int     cyc = 0;
  int     prev_end [3];
  bit     abort [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  uart_tx_fifo dut0 (
    .clk(clk), .resetn(resetn), .cfg_div(div_r[0]), .tx_valid(vld[0]), .tx_data(dat[0]),
    .tx_ready(rdy[0]), .fifo_level(lvl[0]), .tx_busy(busy[0]), .uart_txd(txd[0]));

  uart_tx_fifo #(.PARITY(2), .STOP_BITS(2)) dut1 (
    .clk(clk), .resetn(resetn), .cfg_div(div_r[1]), .tx_valid(vld[1]), .tx_data(dat[1]),
    .tx_ready(rdy[1]), .fifo_level(lvl[1]), .tx_busy(busy[1]), .uart_txd(txd[1]));

  uart_tx_fifo #(.PARITY(1)) dut2 (
    .clk(clk), .resetn(resetn), .cfg_div(div_r[2]), .tx_valid(vld[2]), .tx_data(dat[2]),
    .tx_ready(rdy[2]), .fifo_level(lvl[2]), .tx_busy(busy[2]), .uart_txd(txd[2]));

  task automatic chk(string name, int act, int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic frame_t mk(logic [7:0] d, int par, int stops, int div, int gap);
    frame_t f;
    f.bits    = '1;
    f.bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) f.bits[1+i] = d[i];
    f.len = 9;
    if (par != 0) begin
      f.bits[9] = (par == 2) ? ^d : ~^d;
      f.len = 10;
    end
    f.len += stops;
    f.div = div;
    f.gap = gap;
    return f;
  endfunction

  function automatic frame_t lit(logic [15:0] bits, int len, int div, int gap);
    frame_t f;
    f.bits = bits;
    f.len  = len;
    f.div  = div;
    f.gap  = gap;
    return f;
  endfunction

  task automatic monitor(input int idx);
    frame_t f;
    bit     dead;
    int     got;
    forever begin
      @(negedge clk);
      if (txd[idx] === 1'b0) begin
        if (exp_q[idx].size() == 0) begin
          chk($sformatf("dut%0d_unexpected_frame", idx), 1, 0);
          for (int w = 0; w < 200 && txd[idx] === 1'b0; w++) @(negedge clk);
        end else begin
          f = exp_q[idx].pop_front();
          if (f.gap >= 0)
            chk($sformatf("dut%0d_gap", idx), cyc - prev_end[idx] - 1, f.gap);
          dead = 1'b0;
          for (int j = 0; j < f.len && !dead; j++) begin
            got = f.bits[j];
            for (int k = 0; k < f.div && !dead; k++) begin
              if (j != 0 || k != 0) @(negedge clk);
              if (abort[idx]) dead = 1'b1;
              else if (txd[idx] !== f.bits[j]) got = txd[idx];
            end
            if (!dead) chk($sformatf("dut%0d_bit%0d", idx, j), got, f.bits[j]);
          end
          prev_end[idx] = cyc;
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);

  task automatic push_raw(input int idx, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    vld[idx] = 1'b1;
    dat[idx] = d;
    while (!rdy[idx] && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk($sformatf("dut%0d_push_timeout", idx), 0, 1);
    @(posedge clk);
    #1;
    vld[idx] = 1'b0;
  endtask

  task automatic push(input int idx, input logic [7:0] d, input frame_t f);
    exp_q[idx].push_back(f);
    push_raw(idx, d);
  endtask

  task automatic wait_idle(input int idx);
    int n = 0;
    @(negedge clk);
    while (busy[idx] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk($sformatf("dut%0d_idle_timeout", idx), 0, 1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    vld = '0;
    for (int i = 0; i < 3; i++) begin
      dat[i]      = '0;
      div_r[i]    = 16'd4;
      prev_end[i] = -1000;
      abort[i]    = 1'b0;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("reset_txd", txd[0], 1);
    chk("reset_ready", rdy[0], 1);
    chk("reset_level", lvl[0], 0);
    chk("reset_busy", busy[0], 0);
    @(negedge clk);
    resetn = 1'b1;

    // 0xA5, 4-cycle bits, start two edges after the push
    push(0, 8'hA5, lit(16'b11_0100_1010, 10, 4, -1));
    chk("latency_after_push", txd[0], 1);
    @(posedge clk); #1;
    chk("latency_n1", txd[0], 1);
    @(posedge clk); #1;
    chk("latency_n2", txd[0], 0);
    wait_idle(0);
    chk("busy_after_a5", busy[0], 0);

    // nine back-to-back words fill the FIFO while the first frame is in flight
    div_r[0] = 16'd2;
    for (int i = 0; i < 9; i++)
      push(0, 8'h10 + 8'(i), mk(8'h10 + 8'(i), 0, 1, 2, (i == 0) ? -1 : 0));
    chk("full_level", lvl[0], 8);
    chk("full_ready", rdy[0], 0);
    @(negedge clk);
    vld[0] = 1'b1;
    dat[0] = 8'hFF;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    chk("push_while_full_level", lvl[0], 8);
    wait_idle(0);

    // parity variants on 0x07
    div_r[1] = 16'd3;
    div_r[2] = 16'd3;
    push(1, 8'h07, lit(16'b1110_0000_1110, 12, 3, -1));
    push(2, 8'h07, lit(16'b100_0000_1110, 11, 3, -1));
    wait_idle(1);
    wait_idle(2);

    // divisor 0 acts as 1; mid-frame divisor change applies to the next frame
    div_r[0] = 16'd0;
    push(0, 8'h5A, mk(8'h5A, 0, 1, 1, -1));
    wait_idle(0);
    div_r[0] = 16'd4;
    push(0, 8'h11, mk(8'h11, 0, 1, 4, -1));
    push(0, 8'h22, mk(8'h22, 0, 1, 8, 0));
    repeat (10) @(posedge clk);
    #1;
    div_r[0] = 16'd8;
    wait_idle(0);

    // reset mid-DATA with three words still queued
    div_r[0] = 16'd4;
    push(0, 8'h55, mk(8'h55, 0, 1, 4, -1));
    push_raw(0, 8'h66);
    push_raw(0, 8'h77);
    push_raw(0, 8'h88);
    repeat (8) @(posedge clk);
    @(negedge clk);
    abort[0] = 1'b1;
    resetn   = 1'b0;
    @(posedge clk); #1;
    chk("midreset_txd", txd[0], 1);
    chk("midreset_level", lvl[0], 0);
    chk("midreset_ready", rdy[0], 1);
    chk("midreset_busy", busy[0], 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    abort[0] = 1'b0;
    lows = 0;
    repeat (80) begin
      @(negedge clk);
      if (txd[0] !== 1'b1) lows++;
    end
    chk("no_frames_after_reset", lows, 0);
    chk("level_after_reset", lvl[0], 0);

    // push lands on the edge where the last stop bit ends
    push(0, 8'h81, mk(8'h81, 0, 1, 4, -1));
    repeat (40) @(posedge clk);
    push(0, 8'h3C, mk(8'h3C, 0, 1, 4, 1));
    chk("stop_edge_push_level", lvl[0], 1);
    @(posedge clk); #1;
    chk("stop_edge_pop_level", lvl[0], 0);
    wait_idle(0);

    for (int i = 0; i < 3; i++)
      chk($sformatf("dut%0d_pending_frames", i), exp_q[i].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
